// File: rtl/dmem_if.sv
// dmem_if: load/store request and response bundle between the memory stage and the data memory
// Ports: req/we/addr/wdata driven by the master; busy/rdata/rvalid/wack/err driven by the slave.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        rvalid;
  logic        wack;
  logic        err;
  modport master(output req, we, addr, wdata, input busy, rdata, rvalid, wack, err);
  modport slave(input req, we, addr, wdata, output busy, rdata, rvalid, wack, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with a fixed wait-state latency and one-cycle responses
// Ports: clk, rst (sync, active-high); bus (dmem_if.slave) carries the request and the
// busy/rdata/rvalid/wack/err response.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic                    mis_q, mis_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];
  logic                    accept, enter_resp, mem_we;
  logic                    unused_hi;
  assign unused_hi = ^bus.addr[31:ADDR_WIDTH+2];
  // While accepting, the live request is used so a zero-wait access can hit the array on the accept edge.
  always_comb begin
    accept     = state_q == IDLE && bus.req;
    we_d       = accept ? bus.we : we_q;
    mis_d      = accept ? bus.addr[1:0] != 2'b00 : mis_q;
    idx_d      = accept ? bus.addr[ADDR_WIDTH+1:2] : idx_q;
    wdata_d    = accept ? bus.wdata : wdata_q;
    enter_resp = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
    mem_we     = enter_resp && we_d && !mis_d;
    rdata_d    = (enter_resp && !we_d && !mis_d) ? mem_q[idx_d] : '0;
    cnt_d      = accept ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    state_d    = enter_resp ? RESP : accept ? WAIT : state_q == RESP ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_d] <= wdata_d;
    end
  end
  assign bus.busy   = state_q != IDLE;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = state_q == RESP && !we_q;
  assign bus.wack   = state_q == RESP && we_q;
  assign bus.err    = state_q == RESP && mis_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, corner sequences and random traffic against a word-array model
module tb_dmem_responder;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_if a_if();
  dmem_if b_if();
  dmem_responder #(.WAIT_CYCLES(W)) dut_a(.clk(clk), .rst(rst), .bus(a_if.slave));
  dmem_responder #(.WAIT_CYCLES(0)) dut_b(.clk(clk), .rst(rst), .bus(b_if.slave));
  int total = 0;
  int bad = 0;
  logic [31:0] model [256];
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          err;
    bit          poke;
  } vec_t;
  vec_t tbl [10];
  function automatic logic [35:0] obs_a();
    return {a_if.busy, a_if.rvalid, a_if.wack, a_if.err, a_if.rdata};
  endfunction
  function automatic logic [35:0] obs_b();
    return {b_if.busy, b_if.rvalid, b_if.wack, b_if.err, b_if.rdata};
  endfunction
  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (busy,rvalid,wack,err,rdata)", name, act, exp);
    end
  endtask
  // One transaction on dut_a; optionally presents a store to 0x24 while busy, which must be ignored.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input bit exp_err, input bit poke);
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    for (int n = 1; n <= W + 1; n++) begin
      @(negedge clk);
      if (n == W + 1) check("resp", obs_a(), {1'b1, !we, we, exp_err, exp_rd});
      else check("wait", obs_a(), {4'b1000, 32'h0});
      a_if.req = poke && n == 1;
      if (a_if.req) begin
        a_if.we = 1'b1; a_if.addr = 32'h24; a_if.wdata = 32'h2222;
      end
    end
    @(negedge clk);
    check("idle", obs_a(), 36'h0);
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask
  initial begin
    logic [31:0] addr, wdata, rd;
    logic [7:0] seen;
    bit we, mis;
    a_if.req = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h12,  32'h5555,     32'h0,        1'b1, 1'b0};
    tbl[4] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h20,  32'h1111,     32'h0,        1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h24,  32'h0,        32'h0,        1'b0, 1'b0};
    tbl[7] = '{1'b0, 32'h20,  32'h0,        32'h1111,     1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'h400, 32'hABCD,     32'h0,        1'b0, 1'b0};
    tbl[9] = '{1'b0, 32'h0,   32'h0,        32'hABCD,     1'b0, 1'b0};
    do_reset();
    @(negedge clk);
    check("reset_a", obs_a(), 36'h0);
    check("reset_b", obs_b(), 36'h0);
    for (int i = 0; i < 10; i++) txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, tbl[i].poke);
    // Reset lands on the edge that would have entered RESP: no store, no pulse.
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 32'h30; a_if.wdata = 32'hCAFE;
    @(negedge clk); a_if.req = 1'b0;
    check("abort_busy", obs_a(), {4'b1000, 32'h0});
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_idle", obs_a(), 36'h0);
    @(negedge clk);
    check("abort_nowack", obs_a(), 36'h0);
    txn(1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 1'b0);
    // Zero wait states: response in the cycle right after acceptance.
    @(negedge clk);
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 32'h10; b_if.wdata = 32'hDEADBEEF;
    @(negedge clk); b_if.req = 1'b0;
    check("w0_wack", obs_b(), {4'b1010, 32'h0});
    @(negedge clk);
    check("w0_idle", obs_b(), 36'h0);
    b_if.req = 1'b1; b_if.we = 1'b0;
    @(negedge clk); b_if.req = 1'b0;
    check("w0_rvalid", obs_b(), {4'b1100, 32'hDEADBEEF});
    @(negedge clk);
    check("w0_after", obs_b(), 36'h0);
    do_reset();
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      addr = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) ? ($urandom & 32'hFFFF_FC00) : 32'h0);
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      wdata = $urandom;
      mis = (addr % 4) != 0;
      rd = (!we && !mis) ? model[(addr / 4) % 256] : 32'h0;
      if (we && !mis) model[(addr / 4) % 256] = wdata;
      txn(we, addr, wdata, rd, mis, $urandom_range(0, 7) == 0);
    end
    // req held high: accepted at edges 0 and 4, responses after edges 2 and 6.
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h4;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      seen[n-1] = a_if.rvalid;
      if (a_if.rvalid) check("b2b_data", obs_a(), {4'b1100, model[1]});
      if (n == 8) a_if.req = 1'b0;
    end
    check("b2b_pattern", {28'h0, seen}, {28'h0, 8'b0100_0100});
    @(negedge clk);
    check("b2b_idle", obs_a(), 36'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
